// File: rtl/jof32_pkg.sv
// rtl/jof32_pkg.sv - shared JOF32 processor opcodes and multiply/divide FSM encoding
package jof32_pkg;

   localparam logic [4:0] OPC_MULT = 5'b01000;
   localparam logic [4:0] OPC_DIV  = 5'b01001;
   localparam logic [4:0] OPC_NOP  = 5'b11111;

   localparam logic [4:0] MULDIV_LAST_ITER = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_t;

   function automatic logic is_muldiv(input logic [4:0] opc);
      return (opc == OPC_MULT) || (opc == OPC_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
module muldiv_step
   import jof32_pkg::*;
(
   input  logic        i_is_div,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_operand,
   output logic [63:0] o_acc
);

   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_acc;
   logic [32:0] w_div_shift;
   logic [31:0] w_div_diff;
   logic        w_div_fits;
   logic [63:0] w_div_acc;

   // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
   assign w_mul_sum = i_acc[0] ? ({1'b0, i_acc[63:32]} + {1'b0, i_operand})
                               : {1'b0, i_acc[63:32]};
   assign w_mul_acc = {w_mul_sum, i_acc[31:1]};

   // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract, restore on borrow.
   assign w_div_shift = {i_acc[63:32], i_acc[31]};
   assign w_div_fits  = (w_div_shift >= {1'b0, i_operand});
   assign w_div_diff  = w_div_shift[31:0] - i_operand;
   assign w_div_acc   = w_div_fits ? {w_div_diff, i_acc[30:0], 1'b1}
                                   : {w_div_shift[31:0], i_acc[30:0], 1'b0};

   assign o_acc = i_is_div ? w_div_acc : w_mul_acc;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential 32-cycle unsigned multiply/divide unit for the EXE stage
module muldiv_seq
   import jof32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  opcode_ex,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        div_by_zero
);

   muldiv_state_t r_state;
   muldiv_state_t w_next_state;

   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic [31:0] r_operand;
   logic [63:0] r_acc;
   logic [31:0] r_result;
   logic        r_dz;

   logic        w_start;
   logic        w_dz_start;
   logic        w_is_div_op;
   logic [63:0] w_step_acc;

   assign w_is_div_op = (opcode_ex == OPC_DIV);

   muldiv_step u_step (
      .i_is_div  (r_is_div),
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .o_acc     (w_step_acc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      w_start      = 1'b0;
      w_dz_start   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (is_muldiv(opcode_ex) && !flush) begin
               stall = 1'b1;
               // A zero divisor skips the iteration loop entirely.
               if (w_is_div_op && (op_b == 32'd0)) begin
                  w_dz_start   = 1'b1;
                  w_next_state = ST_DONE;
               end else begin
                  w_start      = 1'b1;
                  w_next_state = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (flush) begin
               w_next_state = ST_IDLE;
            end else if (r_cnt == MULDIV_LAST_ITER) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= 5'd0;
         r_is_div  <= 1'b0;
         r_operand <= 32'd0;
         r_acc     <= 64'd0;
         r_result  <= 32'd0;
         r_dz      <= 1'b0;
      end else if (w_start) begin
         r_cnt     <= 5'd0;
         r_is_div  <= w_is_div_op;
         r_operand <= w_is_div_op ? op_b : op_a;
         r_acc     <= {32'd0, (w_is_div_op ? op_a : op_b)};
         r_dz      <= 1'b0;
      end else if (w_dz_start) begin
         r_result  <= 32'hFFFF_FFFF;
         r_dz      <= 1'b1;
      end else if ((r_state == ST_BUSY) && !flush) begin
         r_acc <= w_step_acc;
         r_cnt <= r_cnt + 5'd1;
         // Publish only on the final iteration so result holds across an aborted op.
         if (r_cnt == MULDIV_LAST_ITER) begin
            r_result <= w_step_acc[31:0];
         end
      end
   end

   assign result       = r_result;
   assign result_valid = (r_state == ST_DONE);
   assign div_by_zero  = r_dz;

endmodule
